zap_thumb_halfword_splitter: RTL and testbench
==============================================

Name: zap_thumb_halfword_splitter

Overview:
Fetch-side stage between the I-cache/fetch register and the Thumb-to-ARM decoder. In ARM state it forwards each 32-bit word unchanged with a one-cycle registered latency. In Thumb state it buffers the word and emits its two 16-bit halfwords on consecutive cycles. It holds fetch while the second halfword is pending, so the downstream decoder always sees exactly one Thumb instruction in bits [15:0].

Parameters:
RESET_PC, 32'd0, value of o_pc_ff out of reset.

Ports:
i_clk  in  1  clock; all state on rising edge.
i_reset_n  in  1  asynchronous, active-low reset.
i_instruction  in  32  word from I-cache.
i_instruction_valid  in  1  word valid.
i_pc_ff  in  32  byte address associated with i_instruction; bit 1 selects the starting halfword.
i_abort  in  1  instruction abort flag for the word.
i_irq  in  1  IRQ request sampled with the word.
i_fiq  in  1  FIQ request sampled with the word.
i_cpsr_ff_t  in  1  CPSR T bit; 1 selects Thumb state.
i_stall_from_decode  in  1  downstream hold.
i_clear_from_decode  in  1  flush from a taken branch or exception.
o_instruction  out  32  ARM word, or {16'd0, halfword} in Thumb state.
o_instruction_valid  out  1  output valid.
o_pc_ff  out  32  address of the emitted instruction.
o_abort  out  1  abort flag.
o_irq  out  1  IRQ flag.
o_fiq  out  1  FIQ flag.
o_thumb  out  1  T bit captured with the word.
o_stall_to_fetch  out  1  combinational; tells fetch to hold its current word.

Behaviour:
- Reset (async, i_reset_n=0):
  - State goes to S_EMPTY.
  - All outputs go to 0, except o_pc_ff=RESET_PC.
  - Word buffer is cleared.
- States:
  - S_EMPTY: no pending halfword.
  - S_UPPER: buffer holds a Thumb word whose upper halfword is not yet emitted.
- o_stall_to_fetch = (state==S_UPPER) | i_stall_from_decode.
- Accept condition: state==S_EMPTY & i_instruction_valid & !i_stall_from_decode & !i_clear_from_decode.
- On accept, the word, pc, abort, irq, fiq and T are captured. The T bit is frozen for both halves, so a CPSR change mid-word has no effect on that word.
- Accept, T=0:
  - Next cycle: o_instruction=word, o_pc_ff=i_pc_ff, o_thumb=0, valid=1.
  - State stays S_EMPTY.
- Accept, T=1, i_pc_ff[1]=1:
  - Next cycle: o_instruction={16'd0,word[31:16]}, o_pc_ff=i_pc_ff, valid=1.
  - State stays S_EMPTY.
- Accept, T=1, i_pc_ff[1]=0:
  - Next cycle: o_instruction={16'd0,word[15:0]}, o_pc_ff={pc[31:2],2'b00}, valid=1.
  - State goes to S_UPPER.
- S_UPPER with !stall & !clear:
  - Next cycle: o_instruction={16'd0,buf[31:16]}, o_pc_ff={pc[31:2],2'b10}, valid=1.
  - State goes to S_EMPTY.
- Throughput: one instruction per cycle. For an aligned Thumb stream: lower at N+1, upper at N+2, next word's lower at N+3.
- Interrupt flags:
  - o_irq/o_fiq are attached only to the first halfword emitted from a word.
  - They are 0 on the upper halfword, so an interrupt is never taken twice for one word.
- o_abort is attached to every halfword emitted from an aborted word.
- S_EMPTY with no accept and no stall: next cycle valid=0. Data outputs hold their last values.
- i_stall_from_decode=1: all output registers and the state hold. No accept occurs.
- i_clear_from_decode=1 (highest priority, beats stall):
  - Next cycle: valid=0, o_irq=0, o_fiq=0.
  - State goes to S_EMPTY and the pending upper halfword is discarded.
  - The word presented in the same cycle is not accepted.
- Reset asserted mid-operation (including in S_UPPER): immediate return to the reset values above. No halfword is emitted after reset releases until a new accept.
- Width rule: the upper 16 bits of o_instruction are always 0 in Thumb state.

Test Plan:
- ARM pass-through: T=0, word 0xE3A01005, pc 0x100, valid for 1 cycle -> next cycle o_instruction=0xE3A01005, o_pc_ff=0x100, valid=1; the following cycle valid=0.
- Aligned Thumb split: T=1, word 0x4770_2005, pc 0x200 -> cycle+1 o_instruction=0x00002005, pc 0x200; cycle+2 0x00004770, pc 0x202; o_stall_to_fetch=1 during cycle+1 only.
- Unaligned Thumb entry: T=1, word 0xBD00_1C40, pc 0x306 -> single output 0x0000BD00, pc 0x306; state stays S_EMPTY; next word accepted the following cycle.
- Flush in S_UPPER: aligned Thumb word accepted, i_clear_from_decode=1 in cycle+1 -> cycle+2 valid=0; upper half never emitted; new word at cycle+2 accepted and emitted at cycle+3.
- Downstream stall: i_stall_from_decode=1 for 3 cycles while the lower half is on the outputs -> outputs frozen for those 3 cycles; upper half appears on the cycle after the stall drops.
- Interrupt and reset: i_irq=1 with an aligned Thumb word -> o_irq=1 on the lower half and 0 on the upper half. i_reset_n pulsed low in S_UPPER -> outputs 0 asynchronously, o_pc_ff=RESET_PC, no upper half emitted after release.

Source files
------------

// File: rtl/zap_thumb_halfword_splitter.sv
// Fetch-side splitter between the fetch register and the Thumb decoder.
// ARM words pass through after one register stage. Thumb words are emitted as two halfwords.
module zap_thumb_halfword_splitter #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_instruction,
  input  logic        i_instruction_valid,
  input  logic [31:0] i_pc_ff,
  input  logic        i_abort,
  input  logic        i_irq,
  input  logic        i_fiq,
  input  logic        i_cpsr_ff_t,
  input  logic        i_stall_from_decode,
  input  logic        i_clear_from_decode,
  output logic [31:0] o_instruction,
  output logic        o_instruction_valid,
  output logic [31:0] o_pc_ff,
  output logic        o_abort,
  output logic        o_irq,
  output logic        o_fiq,
  output logic        o_thumb,
  output logic        o_stall_to_fetch
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_UPPER = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] bufWord_q, bufWord_d;
  logic [31:0] bufPc_q, bufPc_d;
  logic        bufAbort_q, bufAbort_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic        abort_q, abort_d;
  logic        irq_q, irq_d;
  logic        fiq_q, fiq_d;
  logic        thumb_q, thumb_d;
  logic        accept;

  assign accept = (state_q == S_EMPTY) & i_instruction_valid &
                  ~i_stall_from_decode & ~i_clear_from_decode;

  assign o_stall_to_fetch = (state_q == S_UPPER) | i_stall_from_decode;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= S_EMPTY;
      bufWord_q  <= 32'd0;
      bufPc_q    <= 32'd0;
      bufAbort_q <= 1'b0;
      instr_q    <= 32'd0;
      valid_q    <= 1'b0;
      pc_q       <= RESET_PC;
      abort_q    <= 1'b0;
      irq_q      <= 1'b0;
      fiq_q      <= 1'b0;
      thumb_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bufWord_q  <= bufWord_d;
      bufPc_q    <= bufPc_d;
      bufAbort_q <= bufAbort_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      abort_q    <= abort_d;
      irq_q      <= irq_d;
      fiq_q      <= fiq_d;
      thumb_q    <= thumb_d;
    end
  end

  // Flush beats stall; interrupt flags ride only on the first halfword of a word.
  always_comb begin
    state_d    = state_q;
    bufWord_d  = bufWord_q;
    bufPc_d    = bufPc_q;
    bufAbort_d = bufAbort_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    pc_d       = pc_q;
    abort_d    = abort_q;
    irq_d      = irq_q;
    fiq_d      = fiq_q;
    thumb_d    = thumb_q;

    if (i_clear_from_decode) begin
      state_d = S_EMPTY;
      valid_d = 1'b0;
      irq_d   = 1'b0;
      fiq_d   = 1'b0;
    end else if (i_stall_from_decode) begin
      state_d = state_q;
    end else if (state_q == S_UPPER) begin
      state_d = S_EMPTY;
      instr_d = {16'd0, bufWord_q[31:16]};
      pc_d    = {bufPc_q[31:2], 2'b10};
      valid_d = 1'b1;
      abort_d = bufAbort_q;
      irq_d   = 1'b0;
      fiq_d   = 1'b0;
      thumb_d = 1'b1;
    end else if (accept) begin
      bufWord_d  = i_instruction;
      bufPc_d    = i_pc_ff;
      bufAbort_d = i_abort;
      valid_d    = 1'b1;
      abort_d    = i_abort;
      irq_d      = i_irq;
      fiq_d      = i_fiq;
      thumb_d    = i_cpsr_ff_t;
      if (!i_cpsr_ff_t) begin
        instr_d = i_instruction;
        pc_d    = i_pc_ff;
      end else if (i_pc_ff[1]) begin
        instr_d = {16'd0, i_instruction[31:16]};
        pc_d    = i_pc_ff;
      end else begin
        instr_d = {16'd0, i_instruction[15:0]};
        pc_d    = {i_pc_ff[31:2], 2'b00};
        state_d = S_UPPER;
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  assign o_instruction       = instr_q;
  assign o_instruction_valid = valid_q;
  assign o_pc_ff             = pc_q;
  assign o_abort             = abort_q;
  assign o_irq               = irq_q;
  assign o_fiq               = fiq_q;
  assign o_thumb             = thumb_q;

endmodule

// File: tb/tb_zap_thumb_halfword_splitter.sv
// Scoreboard bench for zap_thumb_halfword_splitter: expected outputs are queued as
// words are driven and compared whenever the splitter presents a freshly advanced output.
module tb_zap_thumb_halfword_splitter;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic [31:0] instr = 32'd0;
  logic        instrValid = 1'b0;
  logic [31:0] pcIn = 32'd0;
  logic        abortIn = 1'b0;
  logic        irqIn = 1'b0;
  logic        fiqIn = 1'b0;
  logic        tBit = 1'b0;
  logic        stallIn = 1'b0;
  logic        clearIn = 1'b0;
  logic [31:0] oInstr;
  logic        oValid;
  logic [31:0] oPc;
  logic        oAbort, oIrq, oFiq, oThumb, oStall;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        abort;
    logic        irq;
    logic        fiq;
    logic        thumb;
  } expT;

  expT  expQ[$];
  expT  monEntry;
  int   checks = 0;
  int   failures = 0;
  logic advanced = 1'b0;

  zap_thumb_halfword_splitter #(.RESET_PC(RST_PC)) dut (
    .i_clk               (clk),
    .i_reset_n           (rstN),
    .i_instruction       (instr),
    .i_instruction_valid (instrValid),
    .i_pc_ff             (pcIn),
    .i_abort             (abortIn),
    .i_irq               (irqIn),
    .i_fiq               (fiqIn),
    .i_cpsr_ff_t         (tBit),
    .i_stall_from_decode (stallIn),
    .i_clear_from_decode (clearIn),
    .o_instruction       (oInstr),
    .o_instruction_valid (oValid),
    .o_pc_ff             (oPc),
    .o_abort             (oAbort),
    .o_irq               (oIrq),
    .o_fiq               (oFiq),
    .o_thumb             (oThumb),
    .o_stall_to_fetch    (oStall)
  );

  always #5 clk = ~clk;

  // A held output during a downstream stall is the same instruction, not a new one.
  always @(posedge clk) advanced <= !stallIn;

  always @(negedge clk) begin
    if (rstN && oValid && advanced) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_output instr=%h pc=%h (no output required)", oInstr, oPc);
      end else begin
        monEntry = expQ.pop_front();
        if ({oInstr, oPc, oAbort, oIrq, oFiq, oThumb} !==
            {monEntry.instr, monEntry.pc, monEntry.abort, monEntry.irq, monEntry.fiq, monEntry.thumb}) begin
          failures++;
          $display("[TB] FAIL scoreboard got instr=%h pc=%h ab=%b irq=%b fiq=%b t=%b required instr=%h pc=%h ab=%b irq=%b fiq=%b t=%b",
                   oInstr, oPc, oAbort, oIrq, oFiq, oThumb,
                   monEntry.instr, monEntry.pc, monEntry.abort, monEntry.irq, monEntry.fiq, monEntry.thumb);
        end
      end
    end
  end

  function automatic void pushExp(input logic [31:0] i, input logic [31:0] p,
                                  input logic a, input logic q, input logic f, input logic t);
    expT e;
    e.instr = i; e.pc = p; e.abort = a; e.irq = q; e.fiq = f; e.thumb = t;
    expQ.push_back(e);
  endfunction

  task automatic applyStimulus(input logic v, input logic [31:0] w, input logic [31:0] p,
                               input logic t, input logic q, input logic f, input logic a);
    instrValid = v; instr = w; pcIn = p; tBit = t; irqIn = q; fiqIn = f; abortIn = a;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rstN = 1'b0;
    step();
    step();
    checks++;
    if ({oValid, oInstr, oAbort, oIrq, oFiq, oThumb, oStall} !== 38'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got valid=%b instr=%h ab=%b irq=%b fiq=%b t=%b stall=%b required all 0",
               oValid, oInstr, oAbort, oIrq, oFiq, oThumb, oStall);
    end
    checks++;
    if (oPc !== RST_PC) begin
      failures++;
      $display("[TB] FAIL reset_pc got %h required %h", oPc, RST_PC);
    end
    rstN = 1'b1;
    step();
  endtask

  task automatic test_arm_passthrough();
    applyStimulus(1'b1, 32'hE3A0_1005, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0);
    pushExp(32'hE3A0_1005, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (oStall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL arm_stall got %b required 0", oStall);
    end
    step();
    checks++;
    if (oValid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL arm_valid_drop got %b required 0", oValid);
    end
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL arm_drain got %0d pending required 0", expQ.size());
    end
  endtask

  task automatic test_thumb_aligned();
    applyStimulus(1'b1, 32'h4770_2005, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0);
    pushExp(32'h0000_2005, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1);
    pushExp(32'h0000_4770, 32'h202, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    checks++;
    if (oStall !== 1'b1) begin
      failures++;
      $display("[TB] FAIL aligned_stall_lower got %b required 1", oStall);
    end
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if (oStall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL aligned_stall_upper got %b required 0", oStall);
    end
    step();
    checks++;
    if (oValid !== 1'b0 || expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL aligned_end got valid=%b pending=%0d required valid=0 pending=0", oValid, expQ.size());
    end
  endtask

  task automatic test_thumb_unaligned();
    applyStimulus(1'b1, 32'hBD00_1C40, 32'h306, 1'b1, 1'b0, 1'b0, 1'b0);
    pushExp(32'h0000_BD00, 32'h306, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    checks++;
    if (oStall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL unaligned_stall got %b required 0", oStall);
    end
    applyStimulus(1'b1, 32'h1234_5678, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0);
    pushExp(32'h1234_5678, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if (oValid !== 1'b0 || expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL unaligned_end got valid=%b pending=%0d required valid=0 pending=0", oValid, expQ.size());
    end
  endtask

  task automatic test_flush_upper();
    applyStimulus(1'b1, 32'h1111_2222, 32'h500, 1'b1, 1'b1, 1'b0, 1'b0);
    pushExp(32'h0000_2222, 32'h500, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h504, 1'b1, 1'b0, 1'b0, 1'b0);
    clearIn = 1'b1;
    stallIn = 1'b1;
    step();
    clearIn = 1'b0;
    stallIn = 1'b0;
    checks++;
    if (oValid !== 1'b0 || oIrq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_valid got valid=%b irq=%b required 0 0", oValid, oIrq);
    end
    applyStimulus(1'b1, 32'hCAFE_F00D, 32'h600, 1'b0, 1'b0, 1'b0, 1'b0);
    pushExp(32'hCAFE_F00D, 32'h600, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if (oValid !== 1'b0 || expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL flush_end got valid=%b pending=%0d required valid=0 pending=0", oValid, expQ.size());
    end
  endtask

  task automatic test_stall();
    applyStimulus(1'b1, 32'h3333_4444, 32'h700, 1'b1, 1'b0, 1'b0, 1'b0);
    pushExp(32'h0000_4444, 32'h700, 1'b0, 1'b0, 1'b0, 1'b1);
    pushExp(32'h0000_3333, 32'h702, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    stallIn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (oValid !== 1'b1 || oInstr !== 32'h0000_4444 || oPc !== 32'h700 || oStall !== 1'b1) begin
        failures++;
        $display("[TB] FAIL stall_hold%0d got valid=%b instr=%h pc=%h stall=%b required 1 00004444 00000700 1",
                 i, oValid, oInstr, oPc, oStall);
      end
    end
    stallIn = 1'b0;
    step();
    step();
    checks++;
    if (oValid !== 1'b0 || expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL stall_end got valid=%b pending=%0d required valid=0 pending=0", oValid, expQ.size());
    end
  endtask

  task automatic test_interrupt_flags();
    applyStimulus(1'b1, 32'h5555_6666, 32'h800, 1'b1, 1'b1, 1'b1, 1'b1);
    pushExp(32'h0000_6666, 32'h800, 1'b1, 1'b1, 1'b1, 1'b1);
    pushExp(32'h0000_5555, 32'h802, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    tBit = 1'b0;
    step();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL irq_drain got %0d pending required 0", expQ.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    logic [31:0] p;
    for (int k = 0; k < 4; k++) begin
      w = $urandom;
      p = 32'h900 + 32'(k * 4);
      applyStimulus(1'b1, w, p, 1'b1, k[0], 1'b0, 1'b0);
      pushExp({16'd0, w[15:0]}, p, 1'b0, k[0], 1'b0, 1'b1);
      pushExp({16'd0, w[31:16]}, p + 32'd2, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      checks++;
      if (oValid !== 1'b1 || oStall !== 1'b1) begin
        failures++;
        $display("[TB] FAIL b2b_lower%0d got valid=%b stall=%b required 1 1", k, oValid, oStall);
      end
      step();
    end
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if (oValid !== 1'b0 || expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL b2b_end got valid=%b pending=%0d required valid=0 pending=0", oValid, expQ.size());
    end
  endtask

  task automatic test_reset_mid_upper();
    applyStimulus(1'b1, 32'h7777_8888, 32'hA00, 1'b1, 1'b0, 1'b0, 1'b0);
    pushExp(32'h0000_8888, 32'hA00, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rstN = 1'b0;
    #1;
    checks++;
    if (oValid !== 1'b0 || oInstr !== 32'd0 || oPc !== RST_PC || oThumb !== 1'b0 || oStall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset got valid=%b instr=%h pc=%h t=%b stall=%b required 0 0 %h 0 0",
               oValid, oInstr, oPc, oThumb, oStall, RST_PC);
    end
    step();
    step();
    rstN = 1'b1;
    step();
    step();
    checks++;
    if (oValid !== 1'b0 || expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL reset_no_upper got valid=%b pending=%0d required valid=0 pending=0", oValid, expQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_arm_passthrough();
    test_thumb_aligned();
    test_thumb_unaligned();
    test_flush_upper();
    test_stall();
    test_interrupt_flags();
    test_back_to_back();
    test_reset_mid_upper();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
